shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle variable-amount shifter for the datapath. It accepts an operand, a shift amount and a shift op through a valid/ready handshake. It then applies a one-bit shift step once per cycle until the amount is exhausted, and holds the result under a valid/ready output handshake. It serves the ALU shift instructions (SLL/SRL/SRA) in the multi-cycle core, trading a barrel shifter for a 1-bit step unit plus a counter.

## Interface
- `WIDTH`, default 32: operand/result width.
- `SHAMT_W`, default 5: shift-amount width; must equal clog2(WIDTH).
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: block can accept; high only in IDLE.
- `in_data`, in, WIDTH: operand.
- `in_shamt`, in, SHAMT_W: shift amount, 0..WIDTH-1.
- `in_op`, in, 2: 00 SLL, 01 SRL, 11 SRA, 10 reserved (treated as SLL).
- `out_valid`, out, 1: result available; high only in DONE.
- `out_ready`, in, 1: consumer takes result.
- `out_data`, out, WIDTH: result; registered.
- `busy`, out, 1: high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `in_ready`=1.
  - On `in_valid && in_ready`, load the data register with `in_data`, the count with `in_shamt` and the op register with `in_op`, then go to SHIFT.
  - Inputs are sampled only at the accept edge.
- SHIFT: each cycle:
  - If count==0, go to DONE; the data register is unchanged.
  - Otherwise apply one step and decrement count.
- Step rules:
  - SLL: data<<1, zero fill.
  - SRL: data>>1, zero fill.
  - SRA: data>>1, MSB replicated.
- DONE: `out_valid`=1 and `out_data`=data register, both stable until `out_valid && out_ready`. Then go to IDLE.
- No new request is accepted in SHIFT or DONE. `in_valid` is ignored there.
- Reset (any state, including mid-shift): abort the operation and go to IDLE.
  - Outputs after reset: `out_valid`=0, `out_data`=0, `busy`=0, `in_ready`=1.
  - Internal state after reset: count=0, op=SLL.
- Count is unsigned SHAMT_W bits and never wraps: decrement happens only when count≠0.
- `out_ready` asserted outside DONE has no effect.

## Timing
- Latency: with accept on edge E0 and `in_shamt`=n, `out_valid` rises after edge E0+n+1.
  - n=0 gives `out_valid` one edge after accept.
  - n=31 gives `out_valid` 32 edges after accept.
- The output handshake completes on the edge where `out_valid && out_ready`. `in_ready` is high in the following cycle.
- Minimum issue interval: n+3 cycles with `out_ready` held high.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.

## Configuration
- `SHIFT_RIGHT_EN` defined:
  - SRL/SRA steps are compiled in.
  - The op register and the MSB-fill logic are present.
- `SHIFT_RIGHT_EN` undefined:
  - Only the SLL step exists and `in_op` is ignored.
  - Every request performs SLL and the op register is removed.
  - The port list is unchanged.

## Structure
- Package `shift_pkg`:
  - `shift_op_t` enum (SLL=2'b00, SRL=2'b01, SRA=2'b11).
  - `shift_state_t` enum (IDLE, SHIFT, DONE).
  - `SHIFT_WIDTH_DEFAULT`=32 constant.
- Sub-module `shift_step`: combinational one-bit step.
  - Inputs: data and op. Output: stepped data.
  - The SLL path is x<<1.
  - Right paths sit inside the `SHIFT_RIGHT_EN` guard.
- `shift_sequencer` owns the FSM, count register, data register and handshakes.

## Test plan
- SLL 0x0000_0001, shamt 4 -> `out_data` 0x0000_0010; `out_valid` 5 edges after accept; `busy` high throughout.
- SRA and SRL of 0x8000_0000, shamt 31 -> SRA 0xFFFF_FFFF, SRL 0x0000_0001; each `out_valid` 32 edges after its accept (needs `SHIFT_RIGHT_EN`).
- shamt 0, data 0xDEAD_BEEF, op SLL -> 0xDEAD_BEEF, `out_valid` 1 edge after accept.
- Backpressure: SLL 0x0000_0003 by 1, `out_ready` low 3 cycles after `out_valid` -> `out_data` held at 0x0000_0006, `in_ready`=0, second `in_valid` ignored; release -> IDLE next cycle, then second request accepted.
- Reset mid-shift: SLL shamt 20, `rst` pulsed at count 10 -> next cycle `out_valid`=0, `out_data`=0, `in_ready`=1; a fresh request completes correctly.
- Without `SHIFT_RIGHT_EN`: op SRA, 0x0000_0003, shamt 1 -> 0x0000_0006.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared op/state encodings and width default for the
//               multi-cycle shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

    localparam int SHIFT_WIDTH_DEFAULT = 32;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational one-bit shift step. Right shifts exist only
//               when SHIFT_RIGHT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_data
);

`ifdef SHIFT_RIGHT_EN
    // Reserved encoding 2'b10 falls through to the left shift.
    always_comb begin
        o_data = i_data << 1;
        case (i_op)
            SRL:     o_data = {1'b0, i_data[WIDTH-1:1]};
            SRA:     o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
            default: o_data = i_data << 1;
        endcase
    end
`else
    logic w_op_unused;
    assign w_op_unused = ^i_op;
    assign o_data      = i_data << 1;
`endif

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle variable-amount shifter, one bit per cycle, with
//               valid/ready on both sides. Macro: SHIFT_RIGHT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH   = SHIFT_WIDTH_DEFAULT,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    shift_state_t       r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_data_q,  w_data_d;
    logic [SHAMT_W-1:0] r_count_q, w_count_d;
    logic [1:0]         w_step_op;
    logic [WIDTH-1:0]   w_step_data;
    logic               w_accept;

    assign w_accept = (r_state_q == IDLE) && in_valid;

`ifdef SHIFT_RIGHT_EN
    logic [1:0] r_op_q, w_op_d;

    always_comb begin
        w_op_d = r_op_q;
        if (w_accept) begin
            w_op_d = in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_q <= SLL;
        end else begin
            r_op_q <= w_op_d;
        end
    end

    assign w_step_op = r_op_q;
`else
    logic w_in_op_unused;
    assign w_in_op_unused = ^in_op;
    assign w_step_op      = SLL;
`endif

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_data (r_data_q),
        .i_op   (w_step_op),
        .o_data (w_step_data)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_data_d  = r_data_q;
        w_count_d = r_count_q;
        case (r_state_q)
            IDLE: begin
                if (in_valid) begin
                    w_data_d  = in_data;
                    w_count_d = in_shamt;
                    w_state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The count==0 cycle is the extra edge that hands off to DONE.
                if (r_count_q == '0) begin
                    w_state_d = DONE;
                end else begin
                    w_data_d  = w_step_data;
                    w_count_d = r_count_q - SHAMT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_data_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_data_q  <= w_data_d;
            r_count_q <= w_count_d;
        end
    end

    assign in_ready  = (r_state_q == IDLE);
    assign out_valid = (r_state_q == DONE);
    assign busy      = (r_state_q == SHIFT) || (r_state_q == DONE);
    assign out_data  = r_data_q;

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench: directed table, handshake corner cases
//               and randomized ops against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    shift_sequencer #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: a shift by n is n applications of the rule, i.e. plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                          input logic [4:0] n);
`ifdef SHIFT_RIGHT_EN
        if (op == 2'b01) return d >> n;
        if (op == 2'b11) return 32'($signed(d) >>> n);
`endif
        return d << n;
    endfunction

    // Wait for out_valid, counting edges since the accept edge; must be at a negedge.
    task automatic wait_done(input string name, input int exp_edges, input bit poke);
        int  cnt     = 0;
        bit  busy_ok = 1'b1;
        while (!out_valid && cnt < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (poke) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
                in_shamt = 5'($urandom);
            end
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        check({name, " latency"}, 32'(cnt), 32'(exp_edges));
        check({name, " busy during shift"}, {31'd0, busy_ok}, 32'd1);
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] n, input logic [31:0] exp);
        int hold;
        check({name, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = n;
        in_op    = op;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        wait_done(name, int'(n) + 1, 1'b1);
        check({name, " out_data"}, out_data, exp);
        check({name, " in_ready done"}, {31'd0, in_ready}, 32'd0);
        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " held data"}, out_data, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid after take"}, {31'd0, out_valid}, 32'd0);
        check({name, " idle after take"}, {30'd0, busy, in_ready}, 32'd1);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{SLL, 32'h0000_0001, 5'd4,  32'h0000_0010};
        vecs[1] = '{SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[2] = '{2'b10, 32'h0000_0003, 5'd2, 32'h0000_000C};
`ifdef SHIFT_RIGHT_EN
        vecs[3] = '{SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[4] = '{SRL, 32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[5] = '{SRA, 32'h0000_0003, 5'd1,  32'h0000_0001};
`else
        vecs[3] = '{SRA, 32'h8000_0000, 5'd31, 32'h0000_0000};
        vecs[4] = '{SRL, 32'h8000_0000, 5'd31, 32'h0000_0000};
        vecs[5] = '{SRA, 32'h0000_0003, 5'd1,  32'h0000_0006};
`endif

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp);
        end

        // Backpressure with a second request waiting.
        in_valid = 1'b1; in_data = 32'h3; in_shamt = 5'd1; in_op = SLL;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("bp first", 2, 1'b0);
        in_valid = 1'b1; in_data = 32'h5; in_shamt = 5'd2; in_op = SLL;
        for (int i = 0; i < 3; i++) begin
            check("bp held data", out_data, 32'h6);
            check("bp in_ready low", {31'd0, in_ready}, 32'd0);
            check("bp out_valid high", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp in_ready after release", {31'd0, in_ready}, 32'd1);
        check("bp out_valid after release", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp second accepted", {31'd0, busy}, 32'd1);
        wait_done("bp second", 3, 1'b0);
        check("bp second data", out_data, 32'h14);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset while ten steps remain.
        in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'd20; in_op = SLL;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        check("mid reset out_data", out_data, 32'd0);
        check("mid reset in_ready", {31'd0, in_ready}, 32'd1);
        do_op("post reset", SLL, 32'h0000_00A5, 5'd3, 32'h0000_0528);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] d;
            logic [4:0]  n;
            op = 2'($urandom);
            d  = $urandom;
            n  = 5'($urandom);
            do_op($sformatf("rand%0d", i), op, d, n, model(op, d, n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_sequencer
`default_nettype wire
